// File: rtl/cpu_common_pkg.sv
// cpu_common: types and constants shared between the control unit, the
// sp stage and the stack sequencer.
//   stack_op_t          - request opcode seen by stack_ctrl
//   sp_operation_t      - command issued to the sp stage each cycle
//   stack_ctrl_state_t  - sequencer FSM states
//   STACK_TOP_ADDR      - empty-stack sp value (also the sp reset value)
package cpu_common;

  typedef enum logic [1:0] {
    PUSH_8  = 2'd0,
    PUSH_16 = 2'd1,
    POP_8   = 2'd2,
    POP_16  = 2'd3
  } stack_op_t;

  typedef enum logic [1:0] {
    SP_NOP   = 2'd0,
    SP_INC_1 = 2'd1,
    SP_DEC_1 = 2'd2
  } sp_operation_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PUSH_HI   = 3'd1,
    PUSH_LO   = 3'd2,
    POP_INC   = 3'd3,
    POP_RD_LO = 3'd4,
    POP_RD_HI = 3'd5,
    POP_CAP   = 3'd6,
    RESP      = 3'd7
  } stack_ctrl_state_t;

  localparam logic [13:0] STACK_TOP_ADDR = 14'h3FFF;

endpackage

// File: rtl/stack_ctrl_if.sv
// stack_ctrl_if: request/response handshake between the control unit
// (master) and the stack sequencer (slave).
//   req_valid/req_ready  - request handshake, accepted when both are high
//   req_op/req_wdata     - opcode and push data
//   rsp_valid            - single-cycle completion pulse, no back-pressure
//   rsp_err/rsp_rdata    - error flag and pop data, qualified by rsp_valid
interface stack_ctrl_if;
  import cpu_common::*;

  logic          req_valid;
  logic          req_ready;
  stack_op_t     req_op;
  logic [15:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_err;
  logic [15:0]   rsp_rdata;

  modport master (
    output req_valid, req_op, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_op, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );

endinterface

// File: rtl/stack_ctrl.sv
// stack_ctrl: push/pop sequencer for the CPU stack. Accepts 8/16-bit
// push/pop requests, steps the sp stage one byte at a time and performs
// byte-wide data-memory accesses. Overflow/underflow are detected on
// accept and reported through the response pulse.
//   clk, rst_n    - clock, synchronous active-low reset
//   reqBus        - request/response handshake (slave side)
//   sp_addr       - current stack pointer (next free byte, grows down)
//   sp_operation  - per-cycle command to the sp stage
//   mem_addr/mem_we/mem_re/mem_wdata/mem_rdata - byte memory port,
//                   read data returns the cycle after mem_re
module stack_ctrl
  import cpu_common::*;
#(
  parameter logic [13:0] STACK_LIMIT = 14'h2000,
  parameter logic [13:0] STACK_TOP   = STACK_TOP_ADDR
) (
  input  logic               clk,
  input  logic               rst_n,
  stack_ctrl_if.slave        reqBus,
  input  logic [13:0]        sp_addr,
  output sp_operation_t      sp_operation,
  output logic [13:0]        mem_addr,
  output logic               mem_we,
  output logic               mem_re,
  output logic [7:0]         mem_wdata,
  input  logic [7:0]         mem_rdata
);

  localparam logic [13:0] LIMIT_PLUS_ONE = STACK_LIMIT + 14'd1;
  localparam logic [13:0] TOP_MINUS_ONE  = STACK_TOP - 14'd1;

  stack_ctrl_state_t state_q;
  stack_op_t         op_q;
  logic [15:0]       wdata_q;
  logic [7:0]        loByte_q;
  logic              rspValid_q;
  logic              rspErr_q;
  logic [15:0]       rspRdata_q;
  logic [13:0]       memAddr_q;
  logic              memWe_q;
  logic              memRe_q;
  logic [7:0]        memWdata_q;
  sp_operation_t     spOp_q;
  logic              boundsErr;

  // Bounds check on the live sp value at the accept edge. A 16-bit push
  // needs two free bytes and a 16-bit pop needs two stored bytes.
  always_comb begin
    boundsErr = 1'b0;
    case (reqBus.req_op)
      PUSH_8:  boundsErr = (sp_addr < STACK_LIMIT);
      PUSH_16: boundsErr = (sp_addr < LIMIT_PLUS_ONE);
      POP_8:   boundsErr = (sp_addr == STACK_TOP);
      POP_16:  boundsErr = (sp_addr >= TOP_MINUS_ONE);
      default: boundsErr = 1'b0;
    endcase
  end

  // Sequencer FSM with registered outputs. Outputs are computed for the
  // state being entered, so sp_addr seen here is still the value before
  // any sp_operation issued in the current cycle takes effect; the +/-1
  // terms compensate for that.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= PUSH_8;
      wdata_q    <= '0;
      loByte_q   <= '0;
      rspValid_q <= 1'b0;
      rspErr_q   <= 1'b0;
      rspRdata_q <= '0;
      memAddr_q  <= '0;
      memWe_q    <= 1'b0;
      memRe_q    <= 1'b0;
      memWdata_q <= '0;
      spOp_q     <= SP_NOP;
    end else begin
      memWe_q    <= 1'b0;
      memRe_q    <= 1'b0;
      spOp_q     <= SP_NOP;
      rspValid_q <= 1'b0;
      rspErr_q   <= 1'b0;
      rspRdata_q <= '0;

      case (state_q)
        IDLE: begin
          if (reqBus.req_valid) begin
            op_q    <= reqBus.req_op;
            wdata_q <= reqBus.req_wdata;
            if (boundsErr) begin
              state_q    <= RESP;
              rspValid_q <= 1'b1;
              rspErr_q   <= 1'b1;
            end else begin
              case (reqBus.req_op)
                PUSH_8: begin
                  state_q    <= PUSH_LO;
                  memWe_q    <= 1'b1;
                  memAddr_q  <= sp_addr;
                  memWdata_q <= reqBus.req_wdata[7:0];
                  spOp_q     <= SP_DEC_1;
                end
                PUSH_16: begin
                  state_q    <= PUSH_HI;
                  memWe_q    <= 1'b1;
                  memAddr_q  <= sp_addr;
                  memWdata_q <= reqBus.req_wdata[15:8];
                  spOp_q     <= SP_DEC_1;
                end
                default: begin
                  state_q <= POP_INC;
                  spOp_q  <= SP_INC_1;
                end
              endcase
            end
          end
        end

        PUSH_HI: begin
          state_q    <= PUSH_LO;
          memWe_q    <= 1'b1;
          memAddr_q  <= sp_addr - 14'd1;
          memWdata_q <= wdata_q[7:0];
          spOp_q     <= SP_DEC_1;
        end

        PUSH_LO: begin
          state_q    <= RESP;
          rspValid_q <= 1'b1;
        end

        POP_INC: begin
          memRe_q   <= 1'b1;
          memAddr_q <= sp_addr + 14'd1;
          if (op_q == POP_16) begin
            state_q <= POP_RD_LO;
            spOp_q  <= SP_INC_1;
          end else begin
            state_q <= POP_RD_HI;
          end
        end

        POP_RD_LO: begin
          state_q   <= POP_RD_HI;
          memRe_q   <= 1'b1;
          memAddr_q <= sp_addr + 14'd1;
        end

        // Read data for the POP_RD_LO access is on mem_rdata now.
        POP_RD_HI: begin
          state_q <= POP_CAP;
          if (op_q == POP_16) begin
            loByte_q <= mem_rdata;
          end
        end

        POP_CAP: begin
          state_q    <= RESP;
          rspValid_q <= 1'b1;
          if (op_q == POP_16) begin
            rspRdata_q <= {mem_rdata, loByte_q};
          end else begin
            rspRdata_q <= {8'h00, mem_rdata};
          end
        end

        RESP: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign reqBus.req_ready = rst_n && (state_q == IDLE);
  assign reqBus.rsp_valid = rspValid_q;
  assign reqBus.rsp_err   = rspErr_q;
  assign reqBus.rsp_rdata = rspRdata_q;
  assign sp_operation     = spOp_q;
  assign mem_addr         = memAddr_q;
  assign mem_we           = memWe_q;
  assign mem_re           = memRe_q;
  assign mem_wdata        = memWdata_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: directed bench for stack_ctrl with a behavioural sp stage
// and byte memory. The DUT runs with STACK_LIMIT=3FFE so the overflow
// boundary sits two bytes below the empty-stack address.
module tb_stack_ctrl;
  import cpu_common::*;

  logic          clk;
  logic          rst_n;
  logic [13:0]   spQ;
  sp_operation_t sp_operation;
  logic [13:0]   mem_addr;
  logic          mem_we;
  logic          mem_re;
  logic [7:0]    mem_wdata;
  logic [7:0]    memRdata;
  logic [7:0]    mem [0:16383];

  int passCount = 0;
  int checkCount = 0;
  int strobeClash = 0;

  logic          weLog   [1:8];
  logic          reLog   [1:8];
  logic [13:0]   addrLog [1:8];
  logic [7:0]    wdLog   [1:8];
  logic [1:0]    spLog   [1:8];
  int            rspCycle;
  logic          rspErrSeen;
  logic [15:0]   rspDataSeen;
  int            reCount;
  int            weCount;
  int            spBusyCount;

  stack_ctrl_if reqBus ();

  stack_ctrl #(
    .STACK_LIMIT (14'h3FFE),
    .STACK_TOP   (14'h3FFF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .reqBus       (reqBus),
    .sp_addr      (spQ),
    .sp_operation (sp_operation),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_re       (mem_re),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (memRdata)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural sp stage, reset together with the sequencer
  always @(posedge clk) begin
    if (!rst_n) spQ <= 14'h3FFF;
    else if (sp_operation == SP_INC_1) spQ <= spQ + 14'd1;
    else if (sp_operation == SP_DEC_1) spQ <= spQ - 14'd1;
  end

  // Byte memory with one-cycle read latency
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) memRdata <= mem[mem_addr];
  end

  // Write and read strobes must never coincide
  always @(negedge clk) begin
    if (mem_we && mem_re) strobeClash++;
  end

  // Global time limit so the bench always ends
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "[TB] timeout");
  end

  // Single comparison point: counts, and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
  endtask

  // Issue one request in the next IDLE cycle and log up to 8 cycles of
  // DUT activity after the accept edge, stopping at the response pulse.
  task automatic applyStimulus(input stack_op_t op, input logic [15:0] wdata);
    @(negedge clk);
    reqBus.req_valid = 1'b1;
    reqBus.req_op    = op;
    reqBus.req_wdata = wdata;
    checkOutput("req_ready before accept", 32'(reqBus.req_ready), 32'h1);
    rspCycle = 0; rspErrSeen = 1'b0; rspDataSeen = '0;
    reCount = 0; weCount = 0; spBusyCount = 0;
    for (int c = 1; c <= 8; c++) begin
      weLog[c] = 1'b0; reLog[c] = 1'b0; addrLog[c] = '0; wdLog[c] = '0; spLog[c] = '0;
    end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) reqBus.req_valid = 1'b0;
      weLog[c]   = mem_we;
      reLog[c]   = mem_re;
      addrLog[c] = mem_addr;
      wdLog[c]   = mem_wdata;
      spLog[c]   = sp_operation;
      if (mem_re) reCount++;
      if (mem_we) weCount++;
      if (sp_operation != SP_NOP) spBusyCount++;
      if (reqBus.rsp_valid) begin
        rspCycle    = c;
        rspErrSeen  = reqBus.rsp_err;
        rspDataSeen = reqBus.rsp_rdata;
        break;
      end
    end
  endtask

  int accCount;
  int rspCount;
  int respAccept;
  int accTimes [0:7];
  logic justAccepted;

  initial begin
    rst_n = 1'b0;
    reqBus.req_valid = 1'b0;
    reqBus.req_op    = PUSH_8;
    reqBus.req_wdata = '0;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("reset req_ready", 32'(reqBus.req_ready), 32'h0);
    checkOutput("reset rsp_valid", 32'(reqBus.rsp_valid), 32'h0);
    checkOutput("reset rsp_rdata", 32'(reqBus.rsp_rdata), 32'h0);
    checkOutput("reset mem_we", 32'(mem_we), 32'h0);
    checkOutput("reset mem_re", 32'(mem_re), 32'h0);
    checkOutput("reset mem_addr", 32'(mem_addr), 32'h0);
    checkOutput("reset sp_operation", 32'(sp_operation), 32'(SP_NOP));
    rst_n = 1'b1;
    #1;
    checkOutput("req_ready after reset", 32'(reqBus.req_ready), 32'h1);

    // PUSH_16 0xBEEF: high byte to 3FFF, low byte to 3FFE
    applyStimulus(PUSH_16, 16'hBEEF);
    checkOutput("push16 hi we", 32'(weLog[1]), 32'h1);
    checkOutput("push16 hi addr", 32'(addrLog[1]), 32'h3FFF);
    checkOutput("push16 hi data", 32'(wdLog[1]), 32'hBE);
    checkOutput("push16 hi spop", 32'(spLog[1]), 32'(SP_DEC_1));
    checkOutput("push16 lo we", 32'(weLog[2]), 32'h1);
    checkOutput("push16 lo addr", 32'(addrLog[2]), 32'h3FFE);
    checkOutput("push16 lo data", 32'(wdLog[2]), 32'hEF);
    checkOutput("push16 rsp cycle", 32'(rspCycle), 32'h3);
    checkOutput("push16 rsp_err", 32'(rspErrSeen), 32'h0);
    checkOutput("push16 sp", 32'(spQ), 32'h3FFD);

    // POP_16: reads 3FFE then 3FFF, returns BEEF
    applyStimulus(POP_16, 16'h0000);
    checkOutput("pop16 rd lo", 32'(reLog[2]), 32'h1);
    checkOutput("pop16 rd lo addr", 32'(addrLog[2]), 32'h3FFE);
    checkOutput("pop16 rd hi", 32'(reLog[3]), 32'h1);
    checkOutput("pop16 rd hi addr", 32'(addrLog[3]), 32'h3FFF);
    checkOutput("pop16 rsp cycle", 32'(rspCycle), 32'h5);
    checkOutput("pop16 rdata", 32'(rspDataSeen), 32'hBEEF);
    checkOutput("pop16 rsp_err", 32'(rspErrSeen), 32'h0);
    checkOutput("pop16 no writes", 32'(weCount), 32'h0);
    checkOutput("pop16 sp", 32'(spQ), 32'h3FFF);

    // Underflow on an empty stack
    applyStimulus(POP_8, 16'h0000);
    checkOutput("pop8 empty rsp cycle", 32'(rspCycle), 32'h1);
    checkOutput("pop8 empty err", 32'(rspErrSeen), 32'h1);
    checkOutput("pop8 empty rdata", 32'(rspDataSeen), 32'h0);
    checkOutput("pop8 empty reads", 32'(reCount), 32'h0);
    checkOutput("pop8 empty sp ops", 32'(spBusyCount), 32'h0);
    applyStimulus(POP_16, 16'h0000);
    checkOutput("pop16 empty rsp cycle", 32'(rspCycle), 32'h1);
    checkOutput("pop16 empty err", 32'(rspErrSeen), 32'h1);
    checkOutput("pop16 empty reads", 32'(reCount), 32'h0);
    checkOutput("pop16 empty sp ops", 32'(spBusyCount), 32'h0);
    checkOutput("pop16 empty sp", 32'(spQ), 32'h3FFF);

    // Limit boundary with STACK_LIMIT=3FFE
    applyStimulus(PUSH_8, 16'hFF11);
    checkOutput("push8 11 rsp cycle", 32'(rspCycle), 32'h2);
    checkOutput("push8 11 err", 32'(rspErrSeen), 32'h0);
    checkOutput("push8 11 addr", 32'(addrLog[1]), 32'h3FFF);
    checkOutput("push8 11 data", 32'(wdLog[1]), 32'h11);
    applyStimulus(PUSH_16, 16'h5566);
    checkOutput("push16 at 3FFE err", 32'(rspErrSeen), 32'h1);
    checkOutput("push16 at 3FFE writes", 32'(weCount), 32'h0);
    applyStimulus(POP_16, 16'h0000);
    checkOutput("pop16 at 3FFE err", 32'(rspErrSeen), 32'h1);
    checkOutput("pop16 at 3FFE sp", 32'(spQ), 32'h3FFE);
    applyStimulus(PUSH_8, 16'h0022);
    checkOutput("push8 22 err", 32'(rspErrSeen), 32'h0);
    checkOutput("push8 22 sp", 32'(spQ), 32'h3FFD);
    applyStimulus(PUSH_8, 16'h0033);
    checkOutput("push8 overflow rsp cycle", 32'(rspCycle), 32'h1);
    checkOutput("push8 overflow err", 32'(rspErrSeen), 32'h1);
    checkOutput("push8 overflow writes", 32'(weCount), 32'h0);
    checkOutput("push8 overflow sp", 32'(spQ), 32'h3FFD);
    applyStimulus(POP_8, 16'h0000);
    checkOutput("pop8 first rsp cycle", 32'(rspCycle), 32'h4);
    checkOutput("pop8 first addr", 32'(addrLog[2]), 32'h3FFE);
    checkOutput("pop8 first rdata", 32'(rspDataSeen), 32'h0022);
    applyStimulus(POP_8, 16'h0000);
    checkOutput("pop8 second rdata", 32'(rspDataSeen), 32'h0011);
    checkOutput("pop8 second err", 32'(rspErrSeen), 32'h0);
    checkOutput("pop8 second sp", 32'(spQ), 32'h3FFF);

    // req_valid held high, alternating PUSH_8/POP_8 after each accept
    @(negedge clk);
    reqBus.req_valid = 1'b1;
    reqBus.req_op    = PUSH_8;
    reqBus.req_wdata = 16'h00A5;
    accCount = 0; rspCount = 0; respAccept = 0; justAccepted = 1'b0;
    for (int c = 0; c < 100 && accCount < 6; c++) begin
      if (justAccepted) begin
        reqBus.req_op = (reqBus.req_op == PUSH_8) ? POP_8 : PUSH_8;
        justAccepted = 1'b0;
      end
      if (reqBus.rsp_valid) rspCount++;
      if (reqBus.rsp_valid && reqBus.req_ready) respAccept++;
      if (reqBus.req_ready) begin
        accTimes[accCount] = c;
        accCount++;
        justAccepted = 1'b1;
      end
      @(negedge clk);
    end
    reqBus.req_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (reqBus.rsp_valid) rspCount++;
      @(negedge clk);
    end
    checkOutput("held accepts", 32'(accCount), 32'h6);
    checkOutput("held responses", 32'(rspCount), 32'h6);
    checkOutput("held accept in RESP", 32'(respAccept), 32'h0);
    checkOutput("held push gap", 32'(accTimes[1] - accTimes[0]), 32'h3);
    checkOutput("held pop gap", 32'(accTimes[2] - accTimes[1]), 32'h5);
    checkOutput("held total span", 32'(accTimes[5] - accTimes[0]), 32'd19);
    checkOutput("held final sp", 32'(spQ), 32'h3FFF);

    // Reset during PUSH_LO of a PUSH_16
    @(negedge clk);
    reqBus.req_valid = 1'b1;
    reqBus.req_op    = PUSH_16;
    reqBus.req_wdata = 16'h1234;
    @(negedge clk);
    reqBus.req_valid = 1'b0;
    checkOutput("abort push_hi we", 32'(mem_we), 32'h1);
    @(negedge clk);
    checkOutput("abort push_lo addr", 32'(mem_addr), 32'h3FFE);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort rsp_valid", 32'(reqBus.rsp_valid), 32'h0);
    checkOutput("abort rsp_err", 32'(reqBus.rsp_err), 32'h0);
    checkOutput("abort mem_we", 32'(mem_we), 32'h0);
    checkOutput("abort mem_addr", 32'(mem_addr), 32'h0);
    checkOutput("abort mem_wdata", 32'(mem_wdata), 32'h0);
    checkOutput("abort sp_operation", 32'(sp_operation), 32'(SP_NOP));
    checkOutput("abort req_ready low", 32'(reqBus.req_ready), 32'h0);
    checkOutput("abort sp reset", 32'(spQ), 32'h3FFF);
    rst_n = 1'b1;
    #1;
    checkOutput("abort req_ready high", 32'(reqBus.req_ready), 32'h1);
    @(negedge clk);
    checkOutput("abort no late rsp", 32'(reqBus.rsp_valid), 32'h0);
    applyStimulus(POP_8, 16'h0000);
    checkOutput("abort then pop8 err", 32'(rspErrSeen), 32'h1);

    checkOutput("no we/re overlap", 32'(strobeClash), 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
